// File: rtl/btn_debounce_if.sv
`default_nettype none
// ============================================================================
// btn_debounce_if : raw button inputs and debounced level/pulse outputs
// Rev 1.0
// ============================================================================

interface btn_debounce_if #(
  parameter int N_BTN = 5
) ();
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             sample_tick;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sample_tick
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output sample_tick
  );
endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : per-button synchronizer, sampled debouncer and auto-repeat
// Rev 1.0
// ============================================================================

module btn_debounce #(
  parameter int CLK_HZ              = 100_000_000,
  parameter int BUTTON_CHK_HZ       = 4096,
  parameter int N_BTN               = 5,
  parameter int STABLE_SAMPLES      = 4,
  parameter bit REPEAT_EN           = 1'b1,
  parameter int REPEAT_DELAY_TICKS  = 2048,
  parameter int REPEAT_PERIOD_TICKS = 410
) (
  input  logic          clk,
  input  logic          rst,
  btn_debounce_if.slave bus
);

  localparam int DIV_RAW = CLK_HZ / BUTTON_CHK_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TICK_W  = $clog2(DIV - 1) + 1;
  localparam int STAB_W  = $clog2(STABLE_SAMPLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_PERIOD_TICKS;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(DIV - 1);
  localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(STABLE_SAMPLES - 1);
  localparam logic [RPT_W-1:0]  DELAY_LAST  = RPT_W'(REPEAT_DELAY_TICKS - 1);
  localparam logic [RPT_W-1:0]  PERIOD_LAST = RPT_W'(REPEAT_PERIOD_TICKS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HELD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  // Shared sample-rate divider
  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;
  logic              tick_w;

  always_comb begin
    tick_w = (tick_q == TICK_LAST);
    tick_d = tick_w ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign bus.sample_tick = tick_w;

  logic [N_BTN-1:0] level_vec;
  logic [N_BTN-1:0] press_vec;
  logic [N_BTN-1:0] release_vec;

  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    logic              meta_q;
    logic              sync_q;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic              level_q;
    logic              level_d;
    logic              press_q;
    logic              press_d;
    logic              release_q;
    logic              release_d;
    logic              rise_w;
    logic              fall_w;
    logic              rpt_w;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [RPT_W-1:0]  rcnt_q;
    logic [RPT_W-1:0]  rcnt_d;

    always_comb begin : debounce
      stab_d  = stab_q;
      level_d = level_q;
      rise_w  = 1'b0;
      fall_w  = 1'b0;
      if (tick_w) begin
        if (sync_q != level_q) begin
          if (stab_q == STAB_LAST) begin
            stab_d  = '0;
            level_d = ~level_q;
            rise_w  = ~level_q;
            fall_w  = level_q;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end else begin
          stab_d = '0;
        end
      end
    end

    // A release accepted on a repeat-due tick overrides the repeat pulse
    always_comb begin : repeat_fsm
      state_d = state_q;
      rcnt_d  = rcnt_q;
      rpt_w   = 1'b0;
      if (fall_w) begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rise_w) begin
              state_d = S_HELD;
              rcnt_d  = '0;
            end
          end
          S_HELD: begin
            if (REPEAT_EN && tick_w) begin
              if (rcnt_q >= DELAY_LAST) begin
                rpt_w   = 1'b1;
                rcnt_d  = '0;
                state_d = S_REPEAT;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end
          S_REPEAT: begin
            if (tick_w) begin
              if (rcnt_q >= PERIOD_LAST) begin
                rpt_w  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_d = S_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end
      press_d   = rise_w | rpt_w;
      release_d = fall_w;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        meta_q    <= 1'b0;
        sync_q    <= 1'b0;
        stab_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state_q   <= S_IDLE;
        rcnt_q    <= '0;
      end else begin
        meta_q    <= bus.btn_raw[b];
        sync_q    <= meta_q;
        stab_q    <= stab_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        state_q   <= state_d;
        rcnt_q    <= rcnt_d;
      end
    end

    assign level_vec[b]   = level_q;
    assign press_vec[b]   = press_q;
    assign release_vec[b] = release_q;
  end

  assign bus.btn_level   = level_vec;
  assign bus.btn_press   = press_vec;
  assign bus.btn_release = release_vec;

endmodule

`default_nettype wire
